// File: rtl/toy_bus_arb_node_dtcm_req_rr3.sv
// rtl/toy_bus_arb_node_dtcm_req_rr3.sv - three-input round-robin arbiter with registered DTCM request stage
module toy_bus_arb_node_dtcm_req_rr3 #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic              in0_opcode,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic              in1_opcode,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,
    input  logic              in2_vld,
    output logic              in2_rdy,
    input  logic              in2_opcode,
    input  logic [DATA_W-1:0] in2_data,
    input  logic [ID_W-1:0]   in2_src_id,
    input  logic [ID_W-1:0]   in2_tgt_id,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_opcode,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_src_id,
    output logic [ID_W-1:0]   out_tgt_id,
    output logic [1:0]        out_grant
);

    logic [1:0] ptr;
    logic [1:0] ptr_eff;
    logic [1:0] win;
    logic [2:0] vld_vec;
    logic [2:0] idx;
    logic       any_vld;
    logic       can_load;
    logic       load;

    assign vld_vec  = {in2_vld, in1_vld, in0_vld};
    // The unreachable pointer value 3 is folded onto 0.
    assign ptr_eff  = (ptr == 2'd3) ? 2'd0 : ptr;
    assign can_load = !out_vld || out_rdy;

    // Walk the search order backwards so the first valid input in ptr order wins.
    always_comb begin
        win     = ptr_eff;
        any_vld = 1'b0;
        idx     = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = {1'b0, ptr_eff} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (vld_vec[idx[1:0]]) begin
                win     = idx[1:0];
                any_vld = 1'b1;
            end
        end
    end

    assign load    = rst_n && can_load && any_vld;
    assign in0_rdy = load && (win == 2'd0);
    assign in1_rdy = load && (win == 2'd1);
    assign in2_rdy = load && (win == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_opcode <= 1'b0;
            out_data   <= '0;
            out_src_id <= '0;
            out_tgt_id <= '0;
            out_grant  <= 2'd0;
            ptr        <= 2'd0;
        end else if (load) begin
            out_vld   <= 1'b1;
            out_grant <= win;
            ptr       <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            case (win)
                2'd1: begin
                    out_opcode <= in1_opcode;
                    out_data   <= in1_data;
                    out_src_id <= in1_src_id;
                    out_tgt_id <= in1_tgt_id;
                end
                2'd2: begin
                    out_opcode <= in2_opcode;
                    out_data   <= in2_data;
                    out_src_id <= in2_src_id;
                    out_tgt_id <= in2_tgt_id;
                end
                default: begin
                    out_opcode <= in0_opcode;
                    out_data   <= in0_data;
                    out_src_id <= in0_src_id;
                    out_tgt_id <= in0_tgt_id;
                end
            endcase
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toy_bus_arb_node_dtcm_req_rr3.sv
// tb/tb_toy_bus_arb_node_dtcm_req_rr3.sv - randomized and directed checks of the DTCM request arbiter against a reference model
module tb_toy_bus_arb_node_dtcm_req_rr3;

    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clk;
    logic              rst_n;
    logic [2:0]        vld;
    logic [2:0]        rdy;
    logic [2:0]        op;
    logic [DATA_W-1:0] data [3];
    logic [ID_W-1:0]   src  [3];
    logic [ID_W-1:0]   tgt  [3];
    logic              out_vld;
    logic              out_rdy;
    logic              out_opcode;
    logic [DATA_W-1:0] out_data;
    logic [ID_W-1:0]   out_src_id;
    logic [ID_W-1:0]   out_tgt_id;
    logic [1:0]        out_grant;

    int total = 0;
    int bad   = 0;

    // Reference model: rotating priority index plus a one-slot output buffer.
    int                m_ptr;
    bit                m_vld;
    bit                m_op;
    logic [DATA_W-1:0] m_data;
    logic [ID_W-1:0]   m_src;
    logic [ID_W-1:0]   m_tgt;
    int                m_grant;
    logic [2:0]        last_hs;

    toy_bus_arb_node_dtcm_req_rr3 #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_vld(vld[0]), .in0_rdy(rdy[0]), .in0_opcode(op[0]), .in0_data(data[0]),
        .in0_src_id(src[0]), .in0_tgt_id(tgt[0]),
        .in1_vld(vld[1]), .in1_rdy(rdy[1]), .in1_opcode(op[1]), .in1_data(data[1]),
        .in1_src_id(src[1]), .in1_tgt_id(tgt[1]),
        .in2_vld(vld[2]), .in2_rdy(rdy[2]), .in2_opcode(op[2]), .in2_data(data[2]),
        .in2_src_id(src[2]), .in2_tgt_id(tgt[2]),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_opcode(out_opcode), .out_data(out_data),
        .out_src_id(out_src_id), .out_tgt_id(out_tgt_id), .out_grant(out_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_op = 0; m_data = '0; m_src = '0; m_tgt = '0; m_grant = 0;
    endtask

    // Check one cycle against the model, then advance both across the clock edge.
    task automatic step();
        bit         found;
        bit         can;
        int         w;
        logic [2:0] er;
        #1;
        found = 0;
        w     = 0;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (!found && vld[i]) begin
                found = 1;
                w     = i;
            end
        end
        can = !m_vld || out_rdy;
        er  = (can && found) ? (3'b001 << w) : 3'b000;
        check("in_rdy", 64'(rdy), 64'(er));
        check("out_vld", 64'(out_vld), 64'(m_vld));
        if (m_vld) begin
            check("out_grant", 64'(out_grant), 64'(m_grant));
            check("out_data", 64'(out_data), 64'(m_data));
            check("out_opcode", 64'(out_opcode), 64'(m_op));
            check("out_src_id", 64'(out_src_id), 64'(m_src));
            check("out_tgt_id", 64'(out_tgt_id), 64'(m_tgt));
        end
        last_hs = er;
        if (can && found) begin
            m_vld   = 1;
            m_op    = op[w];
            m_data  = data[w];
            m_src   = src[w];
            m_tgt   = tgt[w];
            m_grant = w;
            m_ptr   = (w + 1) % 3;
        end else if (out_rdy) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input bit v, input logic [DATA_W-1:0] d,
                          input logic [ID_W-1:0] s, input logic [ID_W-1:0] t, input bit o);
        vld[i] = v; data[i] = d; src[i] = s; tgt[i] = t; op[i] = o;
    endtask

    initial begin
        rst_n = 1'b0; out_rdy = 1'b0; vld = '0; op = '0;
        for (int i = 0; i < 3; i++) set_in(i, 0, '0, '0, '0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset asserted while a packet is stalled in the output stage.
        for (int i = 0; i < 3; i++) set_in(i, 1, 32'h10 + 32'(i), 4'(i), 4'(i + 4), 1);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        step();
        check("stall_vld_before_rst", 64'(out_vld), 64'd1);
        #2 rst_n = 1'b0;
        out_rdy = 1'b1;
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_in_rdy", 64'(rdy), 64'd0);
        check("rst_payload", {out_opcode, out_data, out_src_id, out_tgt_id, out_grant}, 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin with all three inputs held valid.
        for (int i = 0; i < 3; i++) set_in(i, 1, 32'hA0 + 32'(i), 4'(i), 4'(i), 0);
        for (int c = 0; c < 6; c++) begin
            step();
            check("rr_data", 64'(out_data), 64'(32'hA0 + 32'(c % 3)));
            check("rr_grant", 64'(out_grant), 64'(c % 3));
        end

        // Backpressure: 0x55 held while the stage is stalled.
        vld = '0;
        set_in(0, 1, 32'h55, 4'd1, 4'd2, 1);
        step();
        set_in(0, 0, '0, '0, '0, 0);
        set_in(1, 1, 32'h61, 4'd1, 4'd1, 0);
        set_in(2, 1, 32'h62, 4'd2, 4'd2, 0);
        out_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("bp_hold_data", 64'(out_data), 64'h55);
        end
        out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 64'(rdy), 64'b010);
        step();
        check("bp_reload_vld", 64'(out_vld), 64'd1);
        check("bp_reload_data", 64'(out_data), 64'h61);

        // Single requester on input 2.
        vld = '0;
        set_in(2, 1, 32'hC2, 4'd3, 4'd6, 1);
        for (int c = 0; c < 4; c++) begin
            step();
            check("single_hs", 64'(last_hs), 64'b100);
            check("single_ids", {out_tgt_id, out_src_id}, {4'd6, 4'd3});
        end

        // Late arrival: ptr=1, only input 0 pending during a stall, input 1 joins.
        vld = '0;
        set_in(0, 1, 32'h70, 4'd0, 4'd0, 0);
        step();
        out_rdy = 1'b0;
        step();
        step();
        set_in(1, 1, 32'h71, 4'd1, 4'd1, 0);
        step();
        out_rdy = 1'b1;
        step();
        check("late_first", 64'(out_data), 64'h71);
        set_in(1, 0, '0, '0, '0, 0);
        step();
        check("late_second", 64'(out_data), 64'h70);

        // Drain to idle; pointer must not move while idle.
        vld = '0;
        step();
        check("drain_vld", 64'(out_vld), 64'd0);
        step();
        vld = 3'b111;
        #1;
        check("idle_ptr_kept", 64'(rdy), 64'b010);
        step();

        // Randomized traffic with masters holding requests until accepted.
        for (int c = 0; c < 2000; c++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    set_in(i, 1, $urandom, 4'($urandom), 4'($urandom), 1'($urandom));
                end
            end
            step();
            for (int i = 0; i < 3; i++) begin
                if (last_hs[i]) begin
                    set_in(i, 1'($urandom), $urandom, 4'($urandom), 4'($urandom), 1'($urandom));
                end
            end
            if (c % 500 == 499) begin
                #2 rst_n = 1'b0;
                #1;
                check("rand_rst_vld", 64'(out_vld), 64'd0);
                check("rand_rst_rdy", 64'(rdy), 64'd0);
                model_reset();
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
